load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the datapath (ALU result, rt register, control decode) and the word-addressed data memory.
- Converts byte addresses to word indices and performs sign/zero-extended byte and halfword loads.
- Performs byte/halfword stores by read-modify-write, and word loads/stores.
- Stalls the datapath with `stall` while an access is in flight; flags misaligned and out-of-range accesses.

Parameters:
- MEM_WORDS, 100: number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  load/store request; held stable by datapath while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1=zero-extend (lbu/lhu), 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from low bits
- stall  out  1  freeze PC/pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- err  out  1  last completed request was misaligned/out-of-range/illegal
- mem_a  out  32  word index to memory
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  32  memory combinational read data

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; rdata, err, done, internal regs = 0.
  - mem_we=0 immediately, even mid-WRITE; the in-flight access is aborted with no write.
- All memory-side outputs decode from registered state/request only.
- mem_a = addr_q[31:2] zero-extended, in every state.
- Byte lanes are little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0].
  - half = bits [15:0] if addr[1]=0, else [31:16].
- State IDLE:
  - stall = req_valid (combinational); done=0.
  - On a clock edge with req_valid=1, latch addr/size/we/unsigned/wdata.
  - Error if any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
  - Next state: error -> DONE with err_next=1; load -> READ; word store -> WRITE; byte/half store -> RMW_RD.
  - On a non-error accept, err_next=0.
- READ: stall=1; rdata <= extracted lane of mem_rd, extended per size/unsigned (word passes through); -> DONE.
- RMW_RD: stall=1; merge_q <= mem_rd; -> WRITE.
- WRITE:
  - stall=1; mem_we=1, exactly one cycle per store.
  - mem_wd = wdata_q for a word store, else merge_q with the addressed lane replaced by wdata_q[7:0] or [15:0].
  - -> DONE.
- DONE:
  - stall=0; done=1; err updated; -> IDLE.
  - req_valid ignored this cycle, since the datapath advances on this edge.
- rdata changes only on READ; stores and errors leave it unchanged.
- mem_we is never asserted for error requests.
- Latency from accept edge to done:
  - load: 2 cycles (stall high 2 cycles).
  - word store: 2 cycles.
  - byte/half store: 3 cycles.
  - error: 1 cycle.
- Back-to-back requests: a new request is sampled only in IDLE, so there is a minimum of one DONE cycle between accesses.

Test Plan:
- sw 0x11223344 to addr 8, then lw addr 8 -> word 2 = 0x11223344; rdata=0x11223344; mem_we high exactly 1 cycle; stall high 2 cycles per op; done pulses once each.
- sb wdata=0x000000AB to addr 9 after the above -> word 2 = 0x1122AB44; stall high 3 cycles; mem_we 1 cycle, in WRITE only.
- lb addr 9 -> rdata=0xFFFFFFAB; lbu addr 9 -> 0x000000AB; lh addr 10 -> 0x00001122; sh 0x8001 to addr 10, then lh addr 10 -> 0xFFFF8001.
- lw addr 6, sh addr 3, req_size=11 -> err=1 with done after 1 cycle; mem_we never asserted; rdata unchanged; next valid access clears err.
- sw to addr 400 (index 100, MEM_WORDS=100) -> err=1, no write; sw to addr 396 -> succeeds, err=0.
- rst=0 asserted while in WRITE of an sb -> mem_we falls immediately; state IDLE; rdata=0, err=0; after rst=1 a fresh lw proceeds normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-addressed data memory.
// Sub-word stores use read-modify-write; stalls the datapath while busy.
module load_store_unit #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_RD,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        bad;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_v;

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
      bad = 1'b1;
  end

  always_comb begin
    ld_b = mem_rd[7:0];
    unique case (addr_q[1:0])
      2'd0: ld_b = mem_rd[7:0];
      2'd1: ld_b = mem_rd[15:8];
      2'd2: ld_b = mem_rd[23:16];
      2'd3: ld_b = mem_rd[31:24];
    endcase
    ld_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_v = mem_rd;
    unique case (1'b1)
      size_q == 2'b00:
        ld_v = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      size_q == 2'b01:
        ld_v = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default:
        ld_v = mem_rd;
    endcase
  end

  // Store data: word goes straight out, sub-word lanes patch merge_q.
  always_comb begin
    mem_wd = merge_q;
    unique case (size_q)
      2'b00: begin
        unique case (addr_q[1:0])
          2'd0: mem_wd[7:0]   = wdata_q[7:0];
          2'd1: mem_wd[15:8]  = wdata_q[7:0];
          2'd2: mem_wd[23:16] = wdata_q[7:0];
          2'd3: mem_wd[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1])
          mem_wd[31:16] = wdata_q[15:0];
        else
          mem_wd[15:0] = wdata_q[15:0];
      end
      default: mem_wd = wdata_q;
    endcase
  end

  assign mem_a = {2'b00, addr_q[31:2]};

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    done    = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (bad)
            state_n = DONE;
          else if (!req_we)
            state_n = READ;
          else if (req_size == 2'b10)
            state_n = WRITE;
          else
            state_n = RMW_RD;
        end
      end
      READ: begin
        stall   = 1'b1;
        state_n = DONE;
      end
      RMW_RD: begin
        stall   = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        stall   = 1'b1;
        mem_we  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        if (bad)
          err <= 1'b1;
      end
      if (state == READ)
        rdata <= ld_v;
      if (state == RMW_RD)
        merge_q <= mem_rd;
      // A good access clears err as it reaches DONE.
      if (state == READ || state == WRITE)
        err <= 1'b0;
    end
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, reference memory and
// a done-driven scoreboard of rdata/err/stall/write counts.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [100];
  logic [31:0] ref_mem [100];
  logic [31:0] last_rd;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          st;
    int          we;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   st_cnt = 0;
  int   we_cnt = 0;

  load_store_unit #(.MEM_WORDS(100)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .stall(stall),
    .done(done),
    .rdata(rdata),
    .err(err),
    .mem_a(mem_a),
    .mem_wd(mem_wd),
    .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_a < 32'd100) ? mem[mem_a[6:0]] : 32'h0;

  always @(posedge clk)
    if (mem_we && mem_a < 32'd100)
      mem[mem_a[6:0]] <= mem_wd;

  // Scoreboard: one entry per request, retired on the done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      st_cnt = 0;
      we_cnt = 0;
      sb_q.delete();
    end else begin
      if (stall) st_cnt++;
      if (mem_we) we_cnt++;
      if (done) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_done: got done, required none");
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          if (rdata !== x.rd) begin
            n_bad++;
            $display("FAIL sb_rdata: got %h required %h", rdata, x.rd);
          end
          if (err !== x.e) begin
            n_bad++;
            $display("FAIL sb_err: got %b required %b", err, x.e);
          end
          if (st_cnt != x.st) begin
            n_bad++;
            $display("FAIL sb_stall_cycles: got %0d required %0d",
                     st_cnt, x.st);
          end
          if (we_cnt != x.we) begin
            n_bad++;
            $display("FAIL sb_mem_we_cycles: got %0d required %0d",
                     we_cnt, x.we);
          end
        end
        st_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic access(input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] wd);
    exp_t        x;
    logic        e;
    int          idx;
    int          sh;
    logic [31:0] wv;
    logic [31:0] mask;
    idx = int'(a >> 2);
    sh  = 8 * int'(a & 32'd3);
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
        (sz == 2'b10 && (a & 32'd3) != 0) || (a >> 2) >= 32'd100;
    x.e  = e;
    x.we = 0;
    if (e) begin
      x.st = 1;
    end else if (!w) begin
      x.st = 2;
      wv = ref_mem[idx] >> sh;
      if (sz == 2'b00)
        last_rd = u ? (wv & 32'hFF) :
                  (wv[7] ? (wv | 32'hFFFF_FF00) : (wv & 32'hFF));
      else if (sz == 2'b01)
        last_rd = u ? (wv & 32'hFFFF) :
                  (wv[15] ? (wv | 32'hFFFF_0000) : (wv & 32'hFFFF));
      else
        last_rd = ref_mem[idx];
    end else begin
      x.st = (sz == 2'b10) ? 2 : 3;
      x.we = 1;
      mask = (sz == 2'b00) ? 32'hFF :
             (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
    end
    x.rd = last_rd;
    sb_q.push_back(x);
    req_valid    = 1'b1;
    req_we       = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL access_timeout: done=%b required 1 addr %h", done, a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({stall, done, err, mem_we} !== 4'b0000 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: got s%b d%b e%b w%b r%h required 0",
               stall, done, err, mem_we, rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word;
    access(1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344);
    n_cmp++;
    if (mem[2] !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL sw_mem: got %h required 11223344", mem[2]);
    end
    access(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL lw_rdata: got %h required 11223344", rdata);
    end
  endtask

  task automatic test_subword;
    access(1'b1, 2'b00, 1'b0, 32'd9, 32'h0000_00AB);
    n_cmp++;
    if (mem[2] !== 32'h1122_AB44) begin
      n_bad++;
      $display("FAIL sb_mem: got %h required 1122AB44", mem[2]);
    end
    access(1'b0, 2'b00, 1'b0, 32'd9, 32'h0);
    n_cmp++;
    if (rdata !== 32'hFFFF_FFAB) begin
      n_bad++;
      $display("FAIL lb_rdata: got %h required FFFFFFAB", rdata);
    end
    access(1'b0, 2'b00, 1'b1, 32'd9, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0000_00AB) begin
      n_bad++;
      $display("FAIL lbu_rdata: got %h required 000000AB", rdata);
    end
    access(1'b0, 2'b01, 1'b0, 32'd10, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0000_1122) begin
      n_bad++;
      $display("FAIL lh_rdata: got %h required 00001122", rdata);
    end
    access(1'b1, 2'b01, 1'b0, 32'd10, 32'h0000_8001);
    n_cmp++;
    if (mem[2] !== 32'h8001_AB44) begin
      n_bad++;
      $display("FAIL sh_mem: got %h required 8001AB44", mem[2]);
    end
    access(1'b0, 2'b01, 1'b0, 32'd10, 32'h0);
    n_cmp++;
    if (rdata !== 32'hFFFF_8001) begin
      n_bad++;
      $display("FAIL lh_neg_rdata: got %h required FFFF8001", rdata);
    end
  endtask

  task automatic test_errors;
    access(1'b0, 2'b10, 1'b0, 32'd6, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'd3, 32'h0000_BEEF);
    access(1'b0, 2'b11, 1'b0, 32'd8, 32'h0);
    n_cmp++;
    if (err !== 1'b1 || rdata !== 32'hFFFF_8001) begin
      n_bad++;
      $display("FAIL err_hold: got e%b r%h required 1 FFFF8001",
               err, rdata);
    end
    access(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    n_cmp++;
    if (err !== 1'b0 || rdata !== 32'h8001_AB44) begin
      n_bad++;
      $display("FAIL err_clear: got e%b r%h required 0 8001AB44",
               err, rdata);
    end
  endtask

  task automatic test_range;
    access(1'b1, 2'b10, 1'b0, 32'd400, 32'hDEAD_BEEF);
    access(1'b1, 2'b10, 1'b0, 32'd396, 32'hCAFE_F00D);
    n_cmp++;
    if (mem[99] !== 32'hCAFE_F00D || err !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_last_word: got %h e%b required CAFEF00D 0",
               mem[99], err);
    end
  endtask

  task automatic test_back_to_back;
    access(1'b0, 2'b10, 1'b0, 32'd396, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'd398, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'd397, 32'h0);
    n_cmp++;
    if (rdata !== 32'hFFFF_FFF0) begin
      n_bad++;
      $display("FAIL b2b_rdata: got %h required FFFFFFF0", rdata);
    end
  endtask

  task automatic test_reset_mid_write;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'd397;
    req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rmw_in_write: mem_we=%b required 1", mem_we);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, stall, done, err} !== 4'b0000 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_abort: got w%b s%b d%b e%b r%h required 0",
               mem_we, stall, done, err, rdata);
    end
    last_rd = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if (mem[99] !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL reset_no_write: got %h required CAFEF00D", mem[99]);
    end
    @(posedge clk);
    #1;
    access(1'b0, 2'b10, 1'b0, 32'd396, 32'h0);
    n_cmp++;
    if (rdata !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL post_reset_lw: got %h required CAFEF00D", rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 100; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    last_rd = 32'h0;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_range();
    test_back_to_back();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
